wb_regfile: RTL and testbench

Writeback stage and architectural register file for the 5-stage RISC-V core. It consumes the MEM/WB pipeline register outputs, selects the writeback value (load data or ALU result), and commits it to a 32-entry register file on the clock edge. It also serves the two decode-stage read ports with same-cycle write-through bypass, and exports the writeback value to the forwarding unit. A retired-write counter is kept for debug and performance visibility.

---
 rtl/wb_regfile.sv | 85 ++++++++
 tb/tb_wb_regfile.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file.
// Selects the writeback value, commits it to the register file, serves two
// decode read ports with same-cycle write-through bypass, exports the
// writeback to the forwarding unit and counts retired register writes.
module wb_regfile #(
  parameter  int XLEN  = 32,
  parameter  int NREG  = 32,
  parameter  int CNT_W = 32,
  localparam int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  mem_data_in,
  input  logic [XLEN-1:0]  alu_result_in,
  input  logic [AW-1:0]    rd_in,
  input  logic             reg_write_in,
  input  logic             mem_to_reg_in,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic             fwd_we,
  output logic [AW-1:0]    fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic [CNT_W-1:0] wb_count
);

  logic [XLEN-1:0]  regs_q [NREG];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [XLEN-1:0]  wb_data;
  logic             we_eff;
  logic [NREG-1:0]  wr_sel;

  // Writeback value and effective write; reset low suppresses the write
  // (and therefore the bypass) so reads return zero while in reset.
  assign wb_data = mem_to_reg_in ? mem_data_in : alu_result_in;
  assign we_eff  = reg_write_in && (rd_in != '0) && reset;
  assign count_d = count_q + CNT_W'(1);

  // One-hot write decode; entry 0 is never selected because we_eff
  // already excludes rd_in == 0.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_wr_sel
    assign wr_sel[gi] = we_eff && (rd_in == AW'(gi));
  end

  // Register file and retired-write counter, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_sel[i]) regs_q[i] <= wb_data;
      end
      if (we_eff) count_q <= count_d;
    end
  end

  // Read port 1: x0 reads zero, then bypass from the write in flight.
  always_comb begin
    rs1_data = regs_q[rs1_addr];
    if (rs1_addr == '0) begin
      rs1_data = '0;
    end else if (we_eff && (rs1_addr == rd_in)) begin
      rs1_data = wb_data;
    end
  end

  // Read port 2: same rules as port 1, evaluated independently.
  always_comb begin
    rs2_data = regs_q[rs2_addr];
    if (rs2_addr == '0) begin
      rs2_data = '0;
    end else if (we_eff && (rs2_addr == rd_in)) begin
      rs2_data = wb_data;
    end
  end

  assign fwd_we   = we_eff;
  assign fwd_rd   = rd_in;
  assign fwd_data = wb_data;
  assign wb_count = count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile with a small counter width so the
// retired-write counter wrap can be reached in a few cycles.
module tb_wb_regfile;
  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [XLEN-1:0]  mem_data_in;
  logic [XLEN-1:0]  alu_result_in;
  logic [4:0]       rd_in;
  logic             reg_write_in;
  logic             mem_to_reg_in;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic             fwd_we;
  logic [4:0]       fwd_rd;
  logic [XLEN-1:0]  fwd_data;
  logic [CNT_W-1:0] wb_count;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: plain architectural view of the register file.
  logic [XLEN-1:0]  m_regs [NREG];
  int               m_writes;

  wb_regfile #(.XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_data_in  (mem_data_in),
    .alu_result_in(alu_result_in),
    .rd_in        (rd_in),
    .reg_write_in (reg_write_in),
    .mem_to_reg_in(mem_to_reg_in),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .fwd_we       (fwd_we),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data),
    .wb_count     (wb_count)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] m_wb();
    return mem_to_reg_in ? mem_data_in : alu_result_in;
  endfunction

  function automatic logic m_we();
    return (reset === 1'b1) && reg_write_in && (rd_in != 5'd0);
  endfunction

  function automatic logic [XLEN-1:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return '0;
    if (m_we() && a == rd_in) return m_wb();
    return m_regs[a];
  endfunction

  function automatic logic [CNT_W-1:0] m_cnt();
    return CNT_W'(m_writes % (1 << CNT_W));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    m_writes = 0;
  endtask

  // Apply one writeback-cycle worth of inputs mid-cycle, then settle.
  task automatic drive(input logic rw, input logic m2r, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic [XLEN-1:0] md, input logic [XLEN-1:0] alu);
    @(negedge clk);
    reg_write_in = rw; mem_to_reg_in = m2r; rd_in = rd;
    rs1_addr = r1; rs2_addr = r2; mem_data_in = md; alu_result_in = alu;
    #1;
  endtask

  // Advance to the committing edge and apply the write to the model.
  task automatic commit();
    @(posedge clk);
    if (m_we()) begin
      m_regs[rd_in] = m_wb();
      m_writes++;
    end
    #1;
  endtask

  task automatic test_reset();
    reg_write_in = 1'b1; rd_in = 5'd10; mem_to_reg_in = 1'b0;
    mem_data_in = $urandom; alu_result_in = $urandom;
    rs1_addr = 5'd10; rs2_addr = 5'd3;
    reset = 1'b1;
    #1 reset = 1'b0;
    model_clear();
    #1;
    n_vec++; if (rs1_data !== 32'd0) begin n_err++; $display("FAIL reset_rs1: got %h expected 0", rs1_data); end
    n_vec++; if (fwd_we !== 1'b0) begin n_err++; $display("FAIL reset_fwd_we: got %b expected 0", fwd_we); end
    @(posedge clk); #1;
    n_vec++; if (wb_count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", wb_count); end
    n_vec++; if (rs1_data !== 32'd0) begin n_err++; $display("FAIL reset_rs1_edge: got %h expected 0", rs1_data); end
    @(negedge clk);
    reg_write_in = 1'b0;
    reset = 1'b1;
    for (int i = 1; i < NREG; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(NREG - i);
      #1;
      n_vec++;
      if (rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
        n_err++; $display("FAIL reset_read x%0d: got %h/%h expected 0/0", i, rs1_data, rs2_data);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_load_wb();
    drive(1'b1, 1'b1, 5'd10, 5'd10, 5'd0, 32'hABCD1234, 32'hDEADBEEF);
    n_vec++; if (rs1_data !== 32'hABCD1234) begin n_err++; $display("FAIL load_bypass: got %h expected abcd1234", rs1_data); end
    n_vec++; if (fwd_we !== 1'b1 || fwd_rd !== 5'd10 || fwd_data !== 32'hABCD1234) begin
      n_err++; $display("FAIL load_fwd: got %b/%0d/%h expected 1/10/abcd1234", fwd_we, fwd_rd, fwd_data);
    end
    commit();
    drive(1'b0, 1'b1, 5'd10, 5'd10, 5'd0, 32'h0, 32'h0);
    n_vec++; if (rs1_data !== 32'hABCD1234) begin n_err++; $display("FAIL load_array: got %h expected abcd1234", rs1_data); end
    n_vec++; if (wb_count !== 4'd1) begin n_err++; $display("FAIL load_count: got %0d expected 1", wb_count); end
    n_vec++; if (fwd_we !== 1'b0) begin n_err++; $display("FAIL load_nowrite_fwd_we: got %b expected 0", fwd_we); end
    commit();
    $display("test_load_wb done");
  endtask

  task automatic test_alu_wb();
    drive(1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 32'hCAFEBABE, 32'h12345678);
    n_vec++; if (fwd_data !== 32'h12345678) begin n_err++; $display("FAIL alu_fwd_data: got %h expected 12345678", fwd_data); end
    commit();
    drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd10, 32'h0BADF00D, 32'h0);
    n_vec++; if (rs1_data !== 32'h12345678) begin n_err++; $display("FAIL alu_x5: got %h expected 12345678", rs1_data); end
    n_vec++; if (rs2_data !== 32'hABCD1234) begin n_err++; $display("FAIL alu_x10: got %h expected abcd1234", rs2_data); end
    n_vec++; if (wb_count !== 4'd2) begin n_err++; $display("FAIL alu_count: got %0d expected 2", wb_count); end
    n_vec++; if (fwd_data !== 32'h0BADF00D) begin n_err++; $display("FAIL alu_steer_nowrite: got %h expected 0badf00d", fwd_data); end
    commit();
    $display("test_alu_wb done");
  endtask

  task automatic test_x0();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    n_vec++; if (rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
      n_err++; $display("FAIL x0_read: got %h/%h expected 0/0", rs1_data, rs2_data);
    end
    n_vec++; if (fwd_we !== 1'b0) begin n_err++; $display("FAIL x0_fwd_we: got %b expected 0", fwd_we); end
    commit();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
    n_vec++; if (wb_count !== 4'd2) begin n_err++; $display("FAIL x0_count: got %0d expected 2", wb_count); end
    commit();
    $display("test_x0 done");
  endtask

  task automatic test_dual_bypass();
    drive(1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 32'h0, 32'h00000011);
    commit();
    drive(1'b1, 1'b0, 5'd7, 5'd7, 5'd7, 32'h0, 32'h00000055);
    n_vec++; if (rs1_data !== 32'h55 || rs2_data !== 32'h55) begin
      n_err++; $display("FAIL dual_bypass: got %h/%h expected 55/55", rs1_data, rs2_data);
    end
    commit();
    drive(1'b0, 1'b0, 5'd7, 5'd7, 5'd7, 32'h0, 32'h0);
    n_vec++; if (rs1_data !== 32'h55 || rs2_data !== 32'h55) begin
      n_err++; $display("FAIL dual_after: got %h/%h expected 55/55", rs1_data, rs2_data);
    end
    n_vec++; if (wb_count !== 4'd4) begin n_err++; $display("FAIL dual_count: got %0d expected 4", wb_count); end
    commit();
    $display("test_dual_bypass done");
  endtask

  task automatic test_random();
    logic [4:0] rd, r1, r2;
    for (int t = 0; t < 200; t++) begin
      rd = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd, r1, r2, $urandom, $urandom);
      n_vec++;
      if (rs1_data !== m_read(r1) || rs2_data !== m_read(r2)) begin
        n_err++; $display("FAIL rand_read t=%0d: got %h/%h expected %h/%h", t, rs1_data, rs2_data, m_read(r1), m_read(r2));
      end
      n_vec++;
      if (fwd_we !== m_we() || fwd_rd !== rd || fwd_data !== m_wb() || wb_count !== m_cnt()) begin
        n_err++; $display("FAIL rand_fwd t=%0d: got %b/%0d/%h/%0d expected %b/%0d/%h/%0d",
                          t, fwd_we, fwd_rd, fwd_data, wb_count, m_we(), rd, m_wb(), m_cnt());
      end
      commit();
    end
    $display("test_random done");
  endtask

  task automatic test_wrap_async_reset();
    @(negedge clk);
    reg_write_in = 1'b0;
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, 1'b0, 5'($urandom_range(1, 31)), 5'd0, 5'd0, $urandom, $urandom);
      commit();
    end
    drive(1'b0, 1'b0, 5'd0, 5'd3, 5'd0, 32'h0, 32'h0);
    n_vec++; if (wb_count !== 4'd1) begin n_err++; $display("FAIL wrap_count: got %0d expected 1", wb_count); end
    // Pending write to x3, then reset pulled low between edges.
    drive(1'b1, 1'b0, 5'd3, 5'd3, 5'd0, 32'h0, 32'h77777777);
    #1 reset = 1'b0;
    model_clear();
    #1;
    n_vec++; if (wb_count !== 4'd0) begin n_err++; $display("FAIL async_count: got %0d expected 0", wb_count); end
    n_vec++; if (fwd_we !== 1'b0 || rs1_data !== 32'd0) begin
      n_err++; $display("FAIL async_bypass: got %b/%h expected 0/0", fwd_we, rs1_data);
    end
    for (int i = 1; i < NREG; i++) begin
      rs2_addr = 5'(i);
      #1;
      n_vec++; if (rs2_data !== 32'd0) begin n_err++; $display("FAIL async_read x%0d: got %h expected 0", i, rs2_data); end
    end
    @(posedge clk); #1;
    @(negedge clk);
    reg_write_in = 1'b0;
    reset = 1'b1;
    rs1_addr = 5'd3;
    #1;
    n_vec++; if (rs1_data !== 32'd0) begin n_err++; $display("FAIL async_nowrite_x3: got %h expected 0", rs1_data); end
    n_vec++; if (wb_count !== 4'd0) begin n_err++; $display("FAIL async_nowrite_count: got %0d expected 0", wb_count); end
    $display("test_wrap_async_reset done");
  endtask

  initial begin
    test_reset();
    test_load_wb();
    test_alu_wb();
    test_x0();
    test_dual_bypass();
    test_random();
    test_wrap_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
